ram_march_bist: RTL and testbench
=================================

# ram_march_bist

Built-in self-test initiator for the 16 x 8 synchronous single-address RAM. On `start` it takes control of the RAM's write/read interface and runs a four-element March test. Each read returns one cycle after it is issued, and the block checks that data and reports pass/fail with the first failing address and data. It sits between the test/control logic and the RAM instance, driving `din`, `addr`, `wr_enb` and `rd_enb` and consuming `dout`.

## Interface

Parameters:
- `DATA_W`, 8, RAM data width.
- `ADDR_W`, 4, RAM address width; depth is 2^ADDR_W.
- `PATTERN`, 8'h55, background pattern P; the inverse pattern is ~P.

Ports:
- `clock`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a test run; sampled only in IDLE.
- `busy`  out  1  high while a test is in progress.
- `done`  out  1  one-cycle pulse at test end.
- `pass`  out  1  result of the last run; held until the next start.
- `fail_addr`  out  ADDR_W  address of the first mismatch.
- `fail_data`  out  DATA_W  data read at the first mismatch.
- `ram_din`  out  DATA_W  write data to the RAM.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wr_enb`  out  1  RAM write enable.
- `ram_rd_enb`  out  1  RAM read enable.
- `ram_dout`  in  DATA_W  RAM read data, valid the cycle after `ram_rd_enb`.
- `err_cnt`  out  8  mismatch count; present only with `RAM_BIST_ERR_CNT_EN`.

## Operation

March elements, run in order:
- M0, ascending: write P.
- M1, ascending: read and expect P, then write ~P.
- M2, descending from 2^ADDR_W-1 to 0: read and expect ~P, then write P.
- M3, ascending: read and expect P.

States:
- IDLE.
- W0.
- R1 and C1.
- R2 and C2.
- R3 and C3.
- DONE.

State rules:
- R states drive `ram_rd_enb`=1 with `ram_addr` set to the current address.
- C states compare `ram_dout` with the expected value.
- In C1 and C2, on a match, drive `ram_wr_enb`=1 and write the new pattern to the same address.
- C3 only compares.
- The element's last address (top for ascending, 0 for descending) advances to the next element; the address counter never wraps.
- `ram_wr_enb` and `ram_rd_enb` are never high in the same cycle.
- All `ram_*` outputs are registered; `ram_din`=0 whenever `ram_wr_enb`=0.

Mismatch handling without the macro:
- On the first mismatch, capture `fail_addr` and `fail_data` (the value actually read).
- Suppress the write in that cycle.
- Go to DONE with `pass`=0.

Other rules:
- `start` while busy, or while in DONE, is ignored. DONE returns to IDLE after one cycle.
- A new run clears `pass`, `fail_addr`, `fail_data` and `err_cnt` in the first busy cycle.
- `pass` is 0 before the first run completes.

## Timing

- Reset: on `rst` high, the next cycle has all outputs 0 (`busy`, `done`, `pass`, `fail_addr`, `fail_data`, `err_cnt`, all `ram_*`) and state IDLE.
- Reset mid-run aborts immediately with no further RAM writes. The RAM shares `rst` and clears too.
- Start: `start` sampled high in IDLE at edge 0. Cycle 1 has `busy`=1, `ram_addr`=0, `ram_wr_enb`=1, `ram_din`=P.
- Cycle counts for a fault-free run with depth 16:
  - M0: 16 cycles.
  - M1, M2, M3: 32 cycles each (2 per address).
  - `busy` is high for cycles 1..112.
  - Cycle 113: `done`=1, `busy`=0, `pass`=1.
- Read latency: read issued in cycle n; `ram_dout` is compared in cycle n+1.
- Abort: with a mismatch in a C cycle k, `done` pulses in cycle k+1 and `busy` is low from cycle k+1.

## Configuration

Macro `RAM_BIST_ERR_CNT_EN`.

Defined:
- Mismatches do not abort; the test always runs all 112 cycles.
- `err_cnt` increments on each mismatch and saturates at 255.
- `fail_addr` and `fail_data` hold the first mismatch.
- The write in a mismatching C1/C2 cycle still occurs.
- `pass` = (`err_cnt`==0) at `done`.

Not defined:
- The `err_cnt` port and its counter are absent.
- The block aborts on the first mismatch.

## Test plan

1. Reset, then a 1-cycle `start` with a good RAM model: `busy` high for exactly 112 cycles, `done` pulse at cycle 113, `pass`=1, `fail_addr`=0, RAM contents all 8'h55 afterwards.
2. RAM model with bit 1 stuck-at-1 at address 5, macro off: abort in M1 at addr 5, `pass`=0, `fail_addr`=5, `fail_data`=8'h57; no write to address 5 after the mismatch.
3. `start` held high for the whole run plus an extra pulse mid-run: exactly one `done`, and the cycle count is unchanged at 112.
4. `rst` asserted during M2: next cycle all outputs 0; a subsequent `start` completes normally with `pass`=1.
5. Macro on, bit 1 stuck-at-1 at addresses 3 and 9: full 112-cycle run, `err_cnt`=4 (M1 and M3 mismatch at each address), `fail_addr`=3, `fail_data`=8'h57, `pass`=0.
6. Bus monitor over a full run: M2 addresses run 15 down to 0, `ram_rd_enb` and `ram_wr_enb` are never both high, and each read is followed by its check cycle.

Source files
------------

// File: rtl/ram_march_bist.sv
// March BIST initiator for a small synchronous single-port RAM (W/R/R/R elements).
// Optional macro RAM_BIST_ERR_CNT_EN: count every mismatch instead of aborting.
module ram_march_bist #(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 4,
    parameter logic [DATA_W-1:0] PATTERN = 8'h55
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [DATA_W-1:0] ram_din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_enb,
    output logic              ram_rd_enb,
    input  logic [DATA_W-1:0] ram_dout
`ifdef RAM_BIST_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam logic [ADDR_W-1:0] A_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] A_MIN = '0;
    localparam logic [DATA_W-1:0] P_INV = ~PATTERN;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W0,
        S_R1,
        S_C1,
        S_R2,
        S_C2,
        S_R3,
        S_C3,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;

    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic              ram_rd_q, ram_rd_d;

`ifdef RAM_BIST_ERR_CNT_EN
    logic [7:0]        err_cnt_q, err_cnt_d;
`endif

    logic              is_cmp;
    logic [DATA_W-1:0] expect_v;
    logic              mismatch;
    logic              abort;
    logic              launch;

    assign launch = (state_q == S_IDLE) && start;

    always_comb begin
        is_cmp   = 1'b0;
        expect_v = PATTERN;
        unique case (state_q)
            S_C1: is_cmp = 1'b1;
            S_C2: begin
                is_cmp   = 1'b1;
                expect_v = P_INV;
            end
            S_C3: is_cmp = 1'b1;
            default: ;
        endcase
    end

    assign mismatch = is_cmp && (ram_dout != expect_v);

`ifdef RAM_BIST_ERR_CNT_EN
    assign abort = 1'b0;
`else
    assign abort = mismatch;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_W0;
                    addr_d  = A_MIN;
                end
            end
            S_W0: begin
                if (addr_q == A_MAX) begin
                    state_d = S_R1;
                    addr_d  = A_MIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_R1: state_d = S_C1;
            S_C1: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (addr_q == A_MAX) begin
                    state_d = S_R2;
                end else begin
                    state_d = S_R1;
                    addr_d  = addr_q + 1'b1;
                end
            end
            S_R2: state_d = S_C2;
            S_C2: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (addr_q == A_MIN) begin
                    state_d = S_R3;
                end else begin
                    state_d = S_R2;
                    addr_d  = addr_q - 1'b1;
                end
            end
            S_R3: state_d = S_C3;
            S_C3: begin
                if (abort || addr_q == A_MAX) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_R3;
                    addr_d  = addr_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus and status registers are loaded for the state being entered.
    always_comb begin
        busy_d    = 1'b0;
        done_d    = 1'b0;
        ram_rd_d  = 1'b0;
        ram_wr_d  = 1'b0;
        ram_din_d = '0;
        unique case (state_d)
            S_W0: begin
                busy_d    = 1'b1;
                ram_wr_d  = 1'b1;
                ram_din_d = PATTERN;
            end
            S_R1, S_R2, S_R3: begin
                busy_d   = 1'b1;
                ram_rd_d = 1'b1;
            end
            S_C1: begin
                busy_d    = 1'b1;
                ram_wr_d  = 1'b1;
                ram_din_d = P_INV;
            end
            S_C2: begin
                busy_d    = 1'b1;
                ram_wr_d  = 1'b1;
                ram_din_d = PATTERN;
            end
            S_C3: busy_d = 1'b1;
            S_DONE: done_d = 1'b1;
            default: ;
        endcase
        ram_addr_d = busy_d ? addr_d : A_MIN;
    end

    always_comb begin
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
`ifdef RAM_BIST_ERR_CNT_EN
        err_cnt_d   = err_cnt_q;
`endif
        if (launch) begin
            pass_d      = 1'b0;
            fail_addr_d = '0;
            fail_data_d = '0;
`ifdef RAM_BIST_ERR_CNT_EN
            err_cnt_d   = '0;
`endif
        end else begin
`ifdef RAM_BIST_ERR_CNT_EN
            if (mismatch && err_cnt_q == 8'd0) begin
                fail_addr_d = addr_q;
                fail_data_d = ram_dout;
            end
            if (mismatch && err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
            if (busy_q && state_d == S_DONE) begin
                pass_d = (err_cnt_d == 8'd0);
            end
`else
            if (mismatch) begin
                fail_addr_d = addr_q;
                fail_data_d = ram_dout;
            end
            if (busy_q && state_d == S_DONE) begin
                pass_d = !mismatch;
            end
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            ram_din_q   <= '0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_rd_q    <= 1'b0;
`ifdef RAM_BIST_ERR_CNT_EN
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            ram_din_q   <= ram_din_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_rd_q    <= ram_rd_d;
`ifdef RAM_BIST_ERR_CNT_EN
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    // A failing cell must not be overwritten, so the compare-cycle write
    // is qualified by the live compare result.
    assign ram_wr_enb = ram_wr_q && !abort;
    assign ram_din    = ram_wr_enb ? ram_din_q : '0;
    assign ram_rd_enb = ram_rd_q;
    assign ram_addr   = ram_addr_q;

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
`ifdef RAM_BIST_ERR_CNT_EN
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_ram_march_bist.sv
// Scoreboard bench for ram_march_bist driving a RAM model with stuck-at faults.
// Expected bus traffic and results come from a March walk over a plain array.
`timescale 1ns/1ps
module tb_ram_march_bist;

    localparam logic [7:0] P = 8'h55;
`ifdef RAM_BIST_ERR_CNT_EN
    localparam bit MACRO = 1'b1;
`else
    localparam bit MACRO = 1'b0;
`endif

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [3:0] addr;
        logic [7:0] din;
    } bus_t;

    typedef struct packed {
        logic        pass;
        logic [3:0]  faddr;
        logic [7:0]  fdata;
        logic [7:0]  ecnt;
        logic [31:0] cyc;
    } res_t;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [3:0] fail_addr;
    logic [7:0] fail_data;
    logic [7:0] ram_din;
    logic [3:0] ram_addr;
    logic       ram_wr_enb, ram_rd_enb;
    logic [7:0] ram_dout;
`ifdef RAM_BIST_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    bus_t bus_q[$];
    res_t res_q[$];
    logic [7:0] mem     [16];
    logic [7:0] exp_mem [16];
    logic [7:0] f_mask  [16];
    logic [7:0] f_val   [16];
    int n_cmp = 0;
    int n_err = 0;

    ram_march_bist dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data),
        .ram_din    (ram_din),
        .ram_addr   (ram_addr),
        .ram_wr_enb (ram_wr_enb),
        .ram_rd_enb (ram_rd_enb),
        .ram_dout   (ram_dout)
`ifdef RAM_BIST_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] flt(input logic [3:0] a, input logic [7:0] d);
        return (d & ~f_mask[a]) | (f_val[a] & f_mask[a]);
    endfunction

    // Synchronous RAM with per-address stuck-at bits; clears on reset.
    always @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
            ram_dout <= 8'h00;
        end else begin
            if (ram_wr_enb) mem[ram_addr] <= flt(ram_addr, ram_din);
            if (ram_rd_enb) ram_dout <= flt(ram_addr, mem[ram_addr]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event occurred with nothing expected at %0t", name, $time);
    endtask

    // Reference: walk the March elements over an array, one entry per busy cycle.
    task automatic build_expect();
        logic [7:0] m [16];
        int err, nrd;
        bit aborted, have_first, bad, w;
        logic [3:0] fa, a;
        logic [7:0] fd, ex, nw, got;
        res_t r;
        err = 0; nrd = 0; aborted = 0; have_first = 0;
        fa = '0; fd = '0;
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            bus_q.push_back('{rd: 1'b0, wr: 1'b1, addr: a, din: P});
            m[i] = flt(a, P);
        end
        for (int e = 1; e <= 3; e++) begin
            for (int i = 0; i < 16; i++) begin
                if (!aborted) begin
                    a   = (e == 2) ? 4'(15 - i) : 4'(i);
                    ex  = (e == 2) ? ~P : P;
                    nw  = (e == 1) ? ~P : P;
                    w   = (e != 3);
                    got = flt(a, m[a]);
                    bad = (got != ex);
                    nrd++;
                    bus_q.push_back('{rd: 1'b1, wr: 1'b0, addr: a, din: 8'h00});
                    if (bad) begin
                        err++;
                        if (!have_first) begin
                            have_first = 1; fa = a; fd = got;
                        end
                        if (!MACRO) begin
                            aborted = 1; w = 0;
                        end
                    end
                    if (w) begin
                        bus_q.push_back('{rd: 1'b0, wr: 1'b1, addr: a, din: nw});
                        m[a] = flt(a, nw);
                    end else begin
                        bus_q.push_back('{rd: 1'b0, wr: 1'b0, addr: a, din: 8'h00});
                    end
                end
            end
        end
        r.pass  = (err == 0);
        r.faddr = fa;
        r.fdata = fd;
        r.ecnt  = (err > 255) ? 8'hFF : 8'(err);
        r.cyc   = 32'(16 + 2 * nrd);
        res_q.push_back(r);
        for (int i = 0; i < 16; i++) exp_mem[i] = m[i];
    endtask

    // Monitor: compares bus each cycle and the result when done pulses.
    int   bcnt = 0;
    logic prev_busy = 1'b0;
    always @(negedge clock) begin
        bus_t e;
        res_t r;
        if (rst) begin
            bcnt      = 0;
            prev_busy = 1'b0;
        end else begin
            chk("rd_wr_excl", 32'(ram_rd_enb & ram_wr_enb), 32'd0);
            if (busy) begin
                bcnt++;
                if (bus_q.size() == 0) fail_now("bus_extra");
                else begin
                    e = bus_q.pop_front();
                    chk("bus_rd", 32'(ram_rd_enb), 32'(e.rd));
                    chk("bus_wr", 32'(ram_wr_enb), 32'(e.wr));
                    chk("bus_addr", 32'(ram_addr), 32'(e.addr));
                    chk("bus_din", 32'(ram_din), 32'(e.din));
                end
            end else begin
                chk("idle_bus", 32'({ram_rd_enb, ram_wr_enb, ram_addr, ram_din}), 32'd0);
            end
            if (prev_busy && !busy) chk("done_after_busy", 32'(done), 32'd1);
            if (done) begin
                if (res_q.size() == 0) fail_now("unexpected_done");
                else begin
                    r = res_q.pop_front();
                    chk("pass", 32'(pass), 32'(r.pass));
                    chk("fail_addr", 32'(fail_addr), 32'(r.faddr));
                    chk("fail_data", 32'(fail_data), 32'(r.fdata));
                    chk("busy_cycles", 32'(bcnt), r.cyc);
                    chk("bus_left", 32'(bus_q.size()), 32'd0);
`ifdef RAM_BIST_ERR_CNT_EN
                    chk("err_cnt", 32'(err_cnt), 32'(r.ecnt));
`endif
                    for (int i = 0; i < 16; i++) chk("ram_mem", 32'(mem[i]), 32'(exp_mem[i]));
                end
                bcnt = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic check_zero();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fail_addr", 32'(fail_addr), 32'd0);
        chk("rst_fail_data", 32'(fail_data), 32'd0);
        chk("rst_ram_bus", 32'({ram_rd_enb, ram_wr_enb, ram_addr, ram_din}), 32'd0);
`ifdef RAM_BIST_ERR_CNT_EN
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 16; i++) begin
            f_mask[i] = 8'h00;
            f_val[i]  = 8'h00;
        end
    endtask

    task automatic run_test(input bit hold);
        int t;
        build_expect();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        chk("busy_cycle1", 32'(busy), 32'd1);
        if (!hold) start = 1'b0;
        t = 0;
        while (!done && t < 400) begin
            @(negedge clock);
            t++;
            if (hold && t == 40) start = 1'b0;
            if (hold && t == 41) start = 1'b1;
        end
        if (!done) begin
            fail_now("done_timeout");
            bus_q.delete();
            res_q.delete();
        end
        @(negedge clock);
        start = 1'b0;
        repeat (hold ? 20 : 3) @(negedge clock);
    endtask

    task automatic reset_mid();
        build_expect();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (59) @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        check_zero();
        bus_q.delete();
        res_q.delete();
        @(negedge clock);
        rst = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        logic [3:0] fa;
        logic [2:0] fb;
        int nf;
        clear_faults();
        rst = 1'b1;
        repeat (3) @(negedge clock);
        check_zero();
        rst = 1'b0;
        @(negedge clock);

        run_test(1'b0);

        f_mask[5] = 8'h02; f_val[5] = 8'h02;
        run_test(1'b0);
        clear_faults();

        f_mask[3] = 8'h02; f_val[3] = 8'h02;
        f_mask[9] = 8'h02; f_val[9] = 8'h02;
        run_test(1'b0);
        clear_faults();

        run_test(1'b1);

        reset_mid();
        run_test(1'b0);

        for (int k = 0; k < 12; k++) begin
            clear_faults();
            nf = int'($urandom_range(0, 2));
            for (int j = 0; j < nf; j++) begin
                fa = 4'($urandom_range(0, 15));
                fb = 3'($urandom_range(0, 7));
                f_mask[fa][fb] = 1'b1;
                f_val[fa][fb]  = 1'($urandom_range(0, 1));
            end
            repeat (int'($urandom_range(0, 5))) @(negedge clock);
            run_test(1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
